// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM controller definitions: read-upsizer FSM encoding and
// width helpers for the WB/memory width ratio (also used by the write downsizer).
package sdram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } rd_state_e;

   localparam int DEF_WB_DW  = 32;
   localparam int DEF_MEM_DW = 16;
   localparam int DEF_SCALE  = DEF_WB_DW / DEF_MEM_DW;
   localparam int DEF_CNT_W  = $clog2(DEF_SCALE);
   localparam int DEF_BOFF_W = $clog2(DEF_WB_DW / 8);

   // Beat counter width for a given width ratio.
   function automatic int cnt_w(input int wb_dw, input int mem_dw);
      return $clog2(wb_dw / mem_dw);
   endfunction

   // Number of byte-offset bits below an address of the given data width.
   function automatic int boff_w(input int dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Collects SCALE narrow beats (low slice first) into one wide word.
// Ports: in_* narrow valid/ready stream, out_* wide valid/ready stream,
// load_o pulses in the cycle the last beat is accepted.
module stream_upsizer
   import sdram_ctrl_pkg::*;
#(
   parameter int DW_IN = 16,
   parameter int SCALE = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DW_IN-1:0]       in_data_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   output logic [SCALE*DW_IN-1:0] out_data_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic                   load_o
);

   localparam int CW = $clog2(SCALE);
   localparam int AS = (SCALE - 1) * DW_IN;

   logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
   logic [AS-1:0]          asm_q, asm_d;
   logic [SCALE*DW_IN-1:0] data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   acc, last;

   assign in_ready_o  = !rst && (!valid_q || out_ready_i);
   assign acc         = in_valid_i && in_ready_o;
   assign last        = (beat_cnt_q == CW'(SCALE - 1));
   assign load_o      = acc && last;
   assign out_data_o  = data_q;
   assign out_valid_o = valid_q;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      asm_d      = asm_q;
      data_d     = data_q;
      valid_d    = valid_q;
      if (valid_q && out_ready_i)
         valid_d = 1'b0;
      if (acc) begin
         if (last) begin
            // A take and a new last beat in one cycle keep valid high.
            data_d     = {in_data_i, asm_q};
            valid_d    = 1'b1;
            beat_cnt_d = '0;
         end else begin
            asm_d[beat_cnt_q*DW_IN +: DW_IN] = in_data_i;
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
         asm_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         asm_q      <= asm_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

endmodule

// File: rtl/mem_rd_upsizer.sv
// Splits one WB-word read into SCALE narrow memory reads and returns the
// assembled word. Ports: s_* wishbone side command/data, m_* SDRAM side.
module mem_rd_upsizer
   import sdram_ctrl_pkg::*;
#(
   parameter int WB_DW  = DEF_WB_DW,
   parameter int MEM_DW = DEF_MEM_DW,
   parameter int AW     = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AW-1:0]                 s_adr_i,
   input  logic                          s_cmd_valid_i,
   output logic                          s_cmd_ready_o,
   output logic [WB_DW-1:0]              s_data_o,
   output logic                          s_data_valid_o,
   input  logic                          s_data_ready_i,
   output logic                          m_we_o,
   output logic [AW+boff_w(WB_DW)-1:0]   m_adr_o,
   output logic                          m_cmd_valid_o,
   input  logic                          m_cmd_ready_i,
   input  logic [MEM_DW-1:0]             m_data_i,
   input  logic                          m_data_valid_i,
   output logic                          m_data_ready_o
);

   localparam int SCALE = WB_DW / MEM_DW;
   localparam int CW    = cnt_w(WB_DW, MEM_DW);
   localparam int MOFF  = boff_w(MEM_DW);
   localparam int OW    = AW + boff_w(WB_DW);

   rd_state_e     state_q, state_d;
   logic [CW-1:0] cmd_cnt_q, cmd_cnt_d;
   logic          cmd_valid, cmd_ready, accept, load;

   assign m_we_o        = 1'b0;
   assign m_cmd_valid_o = cmd_valid && !rst;
   assign s_cmd_ready_o = cmd_ready && !rst;
   assign accept        = m_cmd_valid_o && m_cmd_ready_i;
   // Word address, beat index, then the zero byte offset of a narrow beat.
   assign m_adr_o       = OW'({s_adr_i, cmd_cnt_q}) << MOFF;

   always_comb begin
      state_d   = state_q;
      cmd_cnt_d = cmd_cnt_q;
      cmd_valid = 1'b0;
      cmd_ready = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (s_cmd_valid_i)
               state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            cmd_valid = s_cmd_valid_i;
            if (accept) begin
               if (cmd_cnt_q == CW'(SCALE - 1)) begin
                  cmd_ready = 1'b1;
                  cmd_cnt_d = '0;
                  state_d   = ST_WAIT;
               end else begin
                  cmd_cnt_d = cmd_cnt_q + 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (load)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cmd_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cmd_cnt_q <= cmd_cnt_d;
      end
   end

   stream_upsizer #(
      .DW_IN (MEM_DW),
      .SCALE (SCALE)
   ) u_up (
      .clk         (clk),
      .rst         (rst),
      .in_data_i   (m_data_i),
      .in_valid_i  (m_data_valid_i),
      .in_ready_o  (m_data_ready_o),
      .out_data_o  (s_data_o),
      .out_valid_o (s_data_valid_o),
      .out_ready_i (s_data_ready_i),
      .load_o      (load)
   );

endmodule

// File: tb/tb_mem_rd_upsizer.sv
// Directed self-checking bench for mem_rd_upsizer (32-bit WB, 16-bit memory).
// Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
module tb_mem_rd_upsizer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_adr_i;
   logic        s_cmd_valid_i;
   logic        s_cmd_ready_o;
   logic [31:0] s_data_o;
   logic        s_data_valid_o;
   logic        s_data_ready_i;
   logic        m_we_o;
   logic [33:0] m_adr_o;
   logic        m_cmd_valid_o;
   logic        m_cmd_ready_i;
   logic [15:0] m_data_i;
   logic        m_data_valid_i;
   logic        m_data_ready_o;

   int checks = 0;
   int errors = 0;
   int n_cmd  = 0;
   int n_base;

   always #5 clk = ~clk;

   mem_rd_upsizer #(.WB_DW(32), .MEM_DW(16), .AW(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .s_adr_i        (s_adr_i),
      .s_cmd_valid_i  (s_cmd_valid_i),
      .s_cmd_ready_o  (s_cmd_ready_o),
      .s_data_o       (s_data_o),
      .s_data_valid_o (s_data_valid_o),
      .s_data_ready_i (s_data_ready_i),
      .m_we_o         (m_we_o),
      .m_adr_o        (m_adr_o),
      .m_cmd_valid_o  (m_cmd_valid_o),
      .m_cmd_ready_i  (m_cmd_ready_i),
      .m_data_i       (m_data_i),
      .m_data_valid_i (m_data_valid_i),
      .m_data_ready_o (m_data_ready_o)
   );

   always @(posedge clk)
      if (!rst && m_cmd_valid_o && m_cmd_ready_i)
         n_cmd <= n_cmd + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      s_adr_i        = '0;
      s_cmd_valid_i  = 1'b1;
      s_data_ready_i = 1'b1;
      m_cmd_ready_i  = 1'b1;
      m_data_i       = '0;
      m_data_valid_i = 1'b0;
      step();
      step();
      #1;
      chk("rst_valid", s_data_valid_o, 0);
      chk("rst_data", s_data_o, 0);
      chk("rst_mcmd", m_cmd_valid_o, 0);
      chk("rst_scmd", s_cmd_ready_o, 0);
      chk("rst_mrdy", m_data_ready_o, 0);
      chk("we", m_we_o, 0);
      s_cmd_valid_i = 1'b0;
      step();
      rst = 1'b0;
      step();

      // 1: basic read of word 0x10
      s_adr_i       = 32'h10;
      s_cmd_valid_i = 1'b1;
      #1;
      chk("t1_idle_mcmd", m_cmd_valid_o, 0);
      step();
      #1;
      chk("t1_mcmd0", m_cmd_valid_o, 1);
      chk("t1_adr0", m_adr_o, 34'h40);
      chk("t1_scmd0", s_cmd_ready_o, 0);
      step();
      #1;
      chk("t1_adr1", m_adr_o, 34'h42);
      chk("t1_scmd1", s_cmd_ready_o, 1);
      step();
      s_cmd_valid_i = 1'b0;
      m_data_i       = 16'hBEEF;
      m_data_valid_i = 1'b1;
      #1;
      chk("t1_wait_mcmd", m_cmd_valid_o, 0);
      chk("t1_mrdy", m_data_ready_o, 1);
      step();
      m_data_i = 16'hDEAD;
      #1;
      chk("t1_early_valid", s_data_valid_o, 0);
      step();
      m_data_valid_i = 1'b0;
      #1;
      chk("t1_valid", s_data_valid_o, 1);
      chk("t1_data", s_data_o, 32'hDEADBEEF);
      step();
      #1;
      chk("t1_taken", s_data_valid_o, 0);

      // 2: command stall on beat 1
      s_adr_i       = 32'h3;
      s_cmd_valid_i = 1'b1;
      step();
      #1;
      chk("t2_adr0", m_adr_o, 34'h0C);
      step();
      m_cmd_ready_i = 1'b0;
      #1;
      chk("t2_adr1", m_adr_o, 34'h0E);
      chk("t2_scmd", s_cmd_ready_o, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         chk("t2_hold_v", m_cmd_valid_o, 1);
         chk("t2_hold_a", m_adr_o, 34'h0E);
         chk("t2_hold_r", s_cmd_ready_o, 0);
      end
      m_cmd_ready_i = 1'b1;
      #1;
      chk("t2_scmd_go", s_cmd_ready_o, 1);
      step();
      s_cmd_valid_i = 1'b0;

      // 3: output stall, beats of t2's read
      s_data_ready_i = 1'b0;
      m_data_i       = 16'h1111;
      m_data_valid_i = 1'b1;
      step();
      m_data_i = 16'h2222;
      step();
      m_data_valid_i = 1'b0;
      #1;
      chk("t3_valid", s_data_valid_o, 1);
      chk("t3_data", s_data_o, 32'h22221111);
      for (int i = 0; i < 5; i++) begin
         step();
         #1;
         chk("t3_hold_v", s_data_valid_o, 1);
         chk("t3_hold_d", s_data_o, 32'h22221111);
         chk("t3_mrdy", m_data_ready_o, 0);
         chk("t3_mcmd", m_cmd_valid_o, 0);
      end
      s_data_ready_i = 1'b1;
      #1;
      chk("t3_mrdy_go", m_data_ready_o, 1);
      step();
      #1;
      chk("t3_taken", s_data_valid_o, 0);

      // 4: back-to-back reads 0x0, 0x1
      n_base        = n_cmd;
      s_adr_i       = 32'h0;
      s_cmd_valid_i = 1'b1;
      step();
      #1;
      chk("t4_adr0", m_adr_o, 34'h0);
      step();
      #1;
      chk("t4_adr1", m_adr_o, 34'h2);
      chk("t4_scmd_a", s_cmd_ready_o, 1);
      step();
      s_adr_i        = 32'h1;
      m_data_i       = 16'hA000;
      m_data_valid_i = 1'b1;
      #1;
      chk("t4_wait_mcmd", m_cmd_valid_o, 0);
      step();
      m_data_i = 16'hA001;
      step();
      m_data_valid_i = 1'b0;
      #1;
      chk("t4_word0", s_data_o, 32'hA001A000);
      chk("t4_valid0", s_data_valid_o, 1);
      step();
      #1;
      chk("t4_adr2", m_adr_o, 34'h4);
      chk("t4_valid0_gone", s_data_valid_o, 0);
      step();
      #1;
      chk("t4_adr3", m_adr_o, 34'h6);
      chk("t4_scmd_b", s_cmd_ready_o, 1);
      step();
      s_cmd_valid_i  = 1'b0;
      m_data_i       = 16'hB000;
      m_data_valid_i = 1'b1;
      step();
      m_data_i = 16'hB001;
      step();
      m_data_valid_i = 1'b0;
      #1;
      chk("t4_word1", s_data_o, 32'hB001B000);
      chk("t4_valid1", s_data_valid_o, 1);
      chk("t4_ncmd", n_cmd - n_base, 4);
      step();

      // 5: reset after beat 0, then a fresh read
      s_adr_i       = 32'h5;
      s_cmd_valid_i = 1'b1;
      step();
      step();
      step();
      s_cmd_valid_i  = 1'b0;
      m_data_i       = 16'hDEAD;
      m_data_valid_i = 1'b1;
      step();
      m_data_valid_i = 1'b0;
      rst            = 1'b1;
      s_cmd_valid_i  = 1'b1;
      #1;
      chk("t5_rst_mrdy", m_data_ready_o, 0);
      chk("t5_rst_mcmd", m_cmd_valid_o, 0);
      chk("t5_rst_scmd", s_cmd_ready_o, 0);
      step();
      #1;
      chk("t5_rst_valid", s_data_valid_o, 0);
      chk("t5_rst_data", s_data_o, 0);
      s_cmd_valid_i = 1'b0;
      rst           = 1'b0;
      step();
      s_adr_i       = 32'h7;
      s_cmd_valid_i = 1'b1;
      step();
      #1;
      chk("t5_adr0", m_adr_o, 34'h1C);
      step();
      #1;
      chk("t5_adr1", m_adr_o, 34'h1E);
      chk("t5_scmd", s_cmd_ready_o, 1);
      step();
      s_cmd_valid_i  = 1'b0;
      m_data_i       = 16'h5678;
      m_data_valid_i = 1'b1;
      step();
      m_data_i = 16'h1234;
      #1;
      chk("t5_no_stale", s_data_valid_o, 0);
      step();
      m_data_valid_i = 1'b0;
      #1;
      chk("t5_valid", s_data_valid_o, 1);
      chk("t5_data", s_data_o, 32'h12345678);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
